// File: rtl/snd_pkg.sv
// Shared types and constants for the sound-board command bridge.
package snd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DREAD = 2'd2
  } rd_state_t;

  localparam int PB_CMDSEL   = 6;
  localparam int PB_BANK_LSB = 0;

  // Channel numbers are decoded from the low 3 latched address bits (up to 8 channels).
  localparam int CH_IDX_W = 3;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snd_cmd_chan.sv
// One main-to-MCU command channel: data latch, pending flag and sticky overrun.
module snd_cmd_chan #(
  parameter int CMD_W = 8
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             wr,
  input  logic             clr,
  input  logic [CMD_W-1:0] dat,
  output logic [CMD_W-1:0] cmd,
  output logic             busy,
  output logic             ovr
);

  // A write in the same cycle as the MCU's clear keeps the new command pending.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      cmd  <= '0;
      busy <= 1'b0;
      ovr  <= 1'b0;
    end else if (wr) begin
      cmd  <= dat;
      busy <= 1'b1;
      if (busy) ovr <= 1'b1;
    end else if (clr) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/snd_cmd_bridge.sv
// Glue between main CPU command latches and the 8035 sound MCU: address capture,
// ROM addressing, DB read mux, interrupt stretcher and DAC capture.
module snd_cmd_bridge
  import snd_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CMD_W   = 8,
  parameter int ROM_AW  = 12,
  parameter int INT_MIN = 8
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic [NUM_CH-1:0] I_CMD_WR,
  input  logic [CMD_W-1:0]  I_CMD_DAT,
  output logic [NUM_CH-1:0] O_CMD_BUSY,
  output logic [NUM_CH-1:0] O_CMD_OVR,
  input  logic [7:0]        I8035_DBI,
  output logic [7:0]        I8035_DBO,
  input  logic              I8035_ALE,
  input  logic              I8035_RDn,
  input  logic              I8035_PSENn,
  input  logic [7:0]        I8035_PBI,
  input  logic [7:0]        I8035_PAI,
  output logic              O_INTn,
  output logic [ROM_AW-1:0] O_ROM_A,
  input  logic [7:0]        I_ROM_D,
  output logic [7:0]        O_SOUND_DAT,
  output logic              O_SAMPLE_STB
);

  localparam int SEL_W = sel_w(NUM_CH);
  localparam int CNT_W = $clog2(INT_MIN + 1);

  logic              ale_p1, rdn_p1, psenn_p1;
  logic [7:0]        l_a;
  rd_state_t         state, state_d;
  logic [7:0]        dbo_d, rd_mux;
  logic [NUM_CH-1:0] clr;
  logic [CMD_W-1:0]  cmd [NUM_CH];
  logic [SEL_W-1:0]  ch;
  logic              ch_ok;
  logic [ROM_AW-1:0] rom_a_d;
  logic [CNT_W-1:0]  int_cnt;
  logic              unused_pbi;

  assign unused_pbi = ^{I8035_PBI[7], I8035_PBI[5:ROM_AW-8]};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    snd_cmd_chan #(.CMD_W(CMD_W)) u_chan (
      .I_CLK (I_CLK),
      .I_RST (I_RST),
      .wr    (I_CMD_WR[i]),
      .clr   (clr[i]),
      .dat   (I_CMD_DAT),
      .cmd   (cmd[i]),
      .busy  (O_CMD_BUSY[i]),
      .ovr   (O_CMD_OVR[i])
    );
  end

  // Stage p1: strobe sampling and ALE falling-edge address capture
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      ale_p1   <= 1'b0;
      rdn_p1   <= 1'b1;
      psenn_p1 <= 1'b1;
      l_a      <= '0;
    end else begin
      ale_p1   <= I8035_ALE;
      rdn_p1   <= I8035_RDn;
      psenn_p1 <= I8035_PSENn;
      if (ale_p1 && !I8035_ALE) l_a <= I8035_DBI;
    end
  end

  assign ch    = l_a[SEL_W-1:0];
  assign ch_ok = (int'(l_a[CH_IDX_W-1:0]) < NUM_CH);

  always_comb begin
    rom_a_d = {I8035_PBI[PB_BANK_LSB +: ROM_AW-8], l_a};
    if (!I8035_PBI[PB_CMDSEL] && I8035_PSENn) rom_a_d[ROM_AW-1] = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    if (I8035_PBI[PB_CMDSEL]) begin
      if (ch_ok) rd_mux[CMD_W-1:0] = cmd[ch];
    end else begin
      rd_mux = I_ROM_D;
    end
  end

  // DBO is loaded from the next-state decision so data lands two cycles after the strobe.
  always_comb begin
    state_d = state;
    dbo_d   = '0;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (!psenn_p1) begin
          state_d = FETCH;
          dbo_d   = I_ROM_D;
        end else if (!rdn_p1) begin
          state_d = DREAD;
          dbo_d   = rd_mux;
        end
      end
      FETCH: begin
        if (psenn_p1) state_d = IDLE;
        else          dbo_d   = I_ROM_D;
      end
      DREAD: begin
        if (rdn_p1) begin
          state_d = IDLE;
          if (I8035_PBI[PB_CMDSEL] && ch_ok) clr[ch] = 1'b1;
        end else begin
          dbo_d = rd_mux;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p2: registered bus, address, interrupt and DAC outputs
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state        <= IDLE;
      I8035_DBO    <= '0;
      O_ROM_A      <= '0;
      O_SOUND_DAT  <= '0;
      O_SAMPLE_STB <= 1'b0;
    end else begin
      state        <= state_d;
      I8035_DBO    <= dbo_d;
      O_ROM_A      <= rom_a_d;
      O_SOUND_DAT  <= I8035_PAI;
      O_SAMPLE_STB <= (I8035_PAI != O_SOUND_DAT);
    end
  end

  // int_cnt counts low cycles from the fall and saturates; only a new fall reloads it.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      O_INTn  <= 1'b1;
      int_cnt <= '0;
    end else if (O_INTn) begin
      if (|O_CMD_BUSY) begin
        O_INTn  <= 1'b0;
        int_cnt <= CNT_W'(1);
      end
    end else if (int_cnt >= CNT_W'(INT_MIN)) begin
      if (!(|O_CMD_BUSY)) O_INTn <= 1'b1;
    end else begin
      int_cnt <= int_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_snd_cmd_bridge.sv
// Scoreboard bench for snd_cmd_bridge: expectations are queued with a due cycle
// and compared on the falling clock edge of that cycle.
module tb_snd_cmd_bridge;

  localparam int NUM_CH  = 2;
  localparam int CMD_W   = 8;
  localparam int ROM_AW  = 12;
  localparam int INT_MIN = 8;

  localparam int S_DBO = 0, S_INTN = 1, S_BUSY = 2, S_OVR = 3, S_ROMA = 4, S_SND = 5, S_STB = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
    int          due;
  } sb_ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] wr;
  logic [CMD_W-1:0]  dat;
  logic [NUM_CH-1:0] busy, ovr;
  logic [7:0]        dbi, dbo, pbi, pai, rom_d, rom_q, rom_fix, snd;
  logic              ale, rdn, psenn, intn, stb, rom_fix_en;
  logic [ROM_AW-1:0] rom_a;

  int      cyc = 0;
  int      n_chk = 0;
  int      n_pass = 0;
  int      fall_cyc;
  int      stb_cnt;
  sb_ent_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_f(input logic [ROM_AW-1:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_a);
  assign rom_d = rom_fix_en ? rom_fix : rom_q;

  snd_cmd_bridge #(.NUM_CH(NUM_CH), .CMD_W(CMD_W), .ROM_AW(ROM_AW), .INT_MIN(INT_MIN)) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_CMD_WR     (wr),
    .I_CMD_DAT    (dat),
    .O_CMD_BUSY   (busy),
    .O_CMD_OVR    (ovr),
    .I8035_DBI    (dbi),
    .I8035_DBO    (dbo),
    .I8035_ALE    (ale),
    .I8035_RDn    (rdn),
    .I8035_PSENn  (psenn),
    .I8035_PBI    (pbi),
    .I8035_PAI    (pai),
    .O_INTn       (intn),
    .O_ROM_A      (rom_a),
    .I_ROM_D      (rom_d),
    .O_SOUND_DAT  (snd),
    .O_SAMPLE_STB (stb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_DBO:   return {24'b0, dbo};
      S_INTN:  return {31'b0, intn};
      S_BUSY:  return {30'b0, busy};
      S_OVR:   return {30'b0, ovr};
      S_ROMA:  return {20'b0, rom_a};
      S_SND:   return {24'b0, snd};
      default: return {31'b0, stb};
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sel, input logic [31:0] val, input int d);
    sb_ent_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    e.due = cyc + d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        chk(sb[i].tag, obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ale_latch(input logic [7:0] a);
    dbi = a;
    ale = 1'b1;
    step(1);
    ale = 1'b0;
    step(1);
  endtask

  initial begin
    rst = 1'b1; wr = '0; dat = '0; dbi = '0; ale = 1'b0; rdn = 1'b1; psenn = 1'b1;
    pbi = '0; pai = '0; rom_fix = '0; rom_fix_en = 1'b0;
    step(2);
    expect_at("rst_dbo",  S_DBO,  0, 0);
    expect_at("rst_intn", S_INTN, 1, 0);
    expect_at("rst_busy", S_BUSY, 0, 0);
    expect_at("rst_ovr",  S_OVR,  0, 0);
    expect_at("rst_roma", S_ROMA, 0, 0);
    expect_at("rst_snd",  S_SND,  0, 0);
    expect_at("rst_stb",  S_STB,  0, 0);
    rst = 1'b0;

    // reset in the middle of a command read
    wr = 2'b01; dat = 8'h11;
    step(1);
    wr = '0;
    ale_latch(8'h00);
    pbi = 8'h40; rdn = 1'b0;
    expect_at("dread_pre", S_DBO, 8'h11, 2);
    step(2);
    rst = 1'b1; rdn = 1'b1;
    step(3);
    expect_at("rst_mid_dbo",  S_DBO,  0, 0);
    expect_at("rst_mid_intn", S_INTN, 1, 0);
    expect_at("rst_mid_busy", S_BUSY, 0, 0);
    expect_at("rst_mid_ovr",  S_OVR,  0, 0);
    rst = 1'b0;
    expect_at("rst_idle_dbo", S_DBO, 0, 1);
    step(1);

    // program fetch
    pbi = 8'h03;
    ale_latch(8'h5A);
    rom_fix_en = 1'b1; rom_fix = 8'hC3; psenn = 1'b0;
    expect_at("rom_a_prog", S_ROMA, 12'h35A, 1);
    expect_at("fetch_lat1", S_DBO, 0, 1);
    expect_at("fetch_lat2", S_DBO, 8'hC3, 2);
    step(2);
    rom_fix_en = 1'b0;
    expect_at("fetch_track", S_DBO, rom_f(12'h35A), 1);
    step(1);
    psenn = 1'b1;
    expect_at("fetch_end", S_DBO, 0, 2);
    step(2);

    // command write, read, clear and interrupt stretch
    wr = 2'b10; dat = 8'h3C;
    expect_at("busy_wr1",  S_BUSY, 2'b10, 1);
    expect_at("intn_hold", S_INTN, 1, 1);
    expect_at("intn_fall", S_INTN, 0, 2);
    step(1);
    wr = '0;
    fall_cyc = cyc + 1;
    step(1);
    ale_latch(8'h01);
    pbi = 8'h40; rdn = 1'b0;
    expect_at("cmd_rd1", S_DBO, 8'h3C, 2);
    step(2);
    rdn = 1'b1;
    expect_at("cmd_clr",  S_BUSY, 0, 2);
    expect_at("cmd_idle", S_DBO,  0, 2);
    step(2);
    expect_at("intn_min",  S_INTN, 0, fall_cyc + INT_MIN - 1 - cyc);
    expect_at("intn_rise", S_INTN, 1, fall_cyc + INT_MIN - cyc);
    step(fall_cyc + INT_MIN - cyc + 1);

    // overrun and write/clear collision
    wr = 2'b01; dat = 8'h21;
    step(1);
    wr = '0;
    step(1);
    wr = 2'b01; dat = 8'h42;
    expect_at("ovr_set",  S_OVR,  2'b01, 1);
    expect_at("ovr_busy", S_BUSY, 2'b01, 1);
    step(1);
    wr = '0;
    step(INT_MIN + 2);
    expect_at("intn_busy_hold", S_INTN, 0, 0);
    ale_latch(8'h00);
    pbi = 8'h40; rdn = 1'b0;
    expect_at("ovr_cmd2", S_DBO, 8'h42, 2);
    step(2);
    rdn = 1'b1;
    step(1);
    wr = 2'b01; dat = 8'h77;
    expect_at("collide_busy", S_BUSY, 2'b01, 1);
    expect_at("collide_ovr",  S_OVR,  2'b01, 1);
    step(1);
    wr = '0; rdn = 1'b0;
    expect_at("collide_cmd", S_DBO, 8'h77, 2);
    step(2);
    rdn = 1'b1;
    expect_at("clr_after_collide", S_BUSY, 0, 2);
    expect_at("ovr_sticky",        S_OVR,  2'b01, 2);
    step(2);

    // data ROM read and out-of-range channel
    ale_latch(8'h03);
    pbi = 8'h03; rom_fix_en = 1'b1; rom_fix = 8'hA7; rdn = 1'b0;
    expect_at("drom_dbo",   S_DBO,  8'hA7, 2);
    expect_at("drom_busy",  S_BUSY, 0, 2);
    expect_at("rom_a_data", S_ROMA, 12'hB03, 2);
    step(2);
    rdn = 1'b1;
    step(2);
    rom_fix_en = 1'b0;
    wr = 2'b10; dat = 8'h55;
    step(1);
    wr = '0; pbi = 8'h40; rdn = 1'b0;
    expect_at("oor_dbo", S_DBO, 0, 2);
    step(2);
    rdn = 1'b1;
    expect_at("oor_noclr", S_BUSY, 2'b10, 2);
    step(2);

    // DAC capture
    pai = 8'h80;
    step(3);
    pai = 8'h81;
    expect_at("dac_stb1",    S_STB, 1, 1);
    expect_at("dac_stb_off", S_STB, 0, 2);
    expect_at("dac_dat",     S_SND, 8'h81, 1);
    stb_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (stb) stb_cnt++;
    end
    chk("dac_stb_count", stb_cnt, 1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) chk("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
